temporizador_partida: RTL and testbench
=======================================

# temporizador_partida

Countdown timer for one training match. Sits directly beside the match control unit: it consumes the `zeraT`, `contaT` and `decresceT` strobes and produces the `fimT` flag that ends the match. It keeps the remaining time in whole seconds. It applies a fixed penalty on each wrong move, and exposes the remaining time and a low-time warning for the display path.

## Interface
- `TICKS_POR_SEG`, default 50_000_000: clock cycles per second; must be ≥ 2.
- `TEMPO_INICIAL`, default 60: seconds loaded on reset and on `zeraT`; range 1..255.
- `PENALIDADE`, default 10: seconds subtracted per `decresceT` pulse; range 0..255.
- `LIMIAR_ALERTA`, default 10: `alerta` is high while 0 < tempo ≤ this value.
- `clock`  in  1  system clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `zeraT`  in  1  synchronous reload of the timer.
- `contaT`  in  1  level; while high, time runs.
- `decresceT`  in  1  single-cycle penalty strobe.
- `fimT`  out  1  high while time is exhausted.
- `tempo`  out  8  remaining seconds, unsigned binary.
- `alerta`  out  1  low-time warning.
- `tick`  out  1  one-cycle pulse on each cycle where a second is consumed.
- `db_estado`  out  2  current FSM state, for debug.

## Operation
- **Registers**
  - `tempo` (8 bits).
  - Prescaler `pre`: width is ceil(log2(`TICKS_POR_SEG`)).
  - FSM state (2 bits).
- **States**
  - `PARADO` = 2'b00.
  - `CONTANDO` = 2'b01.
  - `ESGOTADO` = 2'b11.
  - Encoding 2'b10 is illegal and goes to `PARADO` on the next edge.
- **Reset values (reset low):** `tempo` = `TEMPO_INICIAL`, `pre` = 0, state = `PARADO`. Therefore `fimT` = 0, `tick` = 0, `db_estado` = 00, and `alerta` = (`TEMPO_INICIAL` ≤ `LIMIAR_ALERTA`).
- **Priority per cycle:** `zeraT` > exhaustion hold > penalty/tick.
- **`zeraT` = 1:** `tempo` ← `TEMPO_INICIAL`, `pre` ← 0, state ← `PARADO`. Any `decresceT` or tick in that cycle is ignored.
- **Exhaustion hold:** in `ESGOTADO` (and `zeraT` = 0), `tempo` stays 0, `pre` holds, `tick` = 0, and `decresceT` is ignored. The only exit is `zeraT` or `reset`.
- **Prescaler**
  - Advances only when `contaT` = 1 and the state is not `ESGOTADO`.
  - When `pre` = `TICKS_POR_SEG`−1, it wraps to 0 and `tick` = 1 in that same cycle (`tick` is combinational from `pre` and `contaT`).
  - `contaT` = 0 freezes `pre`, so a pause resumes mid-second.
- **Next time value:** `tempo_next` = max(0, `tempo` − (`decresceT` ? `PENALIDADE` : 0) − (`tick` ? 1 : 0)).
  - Computed in 10-bit signed arithmetic, then saturated to 0.
  - A simultaneous penalty and tick therefore subtract `PENALIDADE`+1.
- **Penalty:** `decresceT` applies regardless of `contaT`.
- **Transitions (when `zeraT` = 0)**
  - If `tempo_next` = 0 and the state is not `ESGOTADO` → `ESGOTADO`. This holds even if `tempo` was already 0 through a `TEMPO_INICIAL`/`PENALIDADE` corner case.
  - Otherwise, `PARADO` → `CONTANDO` when `contaT` = 1.
  - Otherwise, `CONTANDO` → `PARADO` when `contaT` = 0.
- **Outputs**
  - `fimT` = (state == `ESGOTADO`), decoded from the state register only.
  - `alerta` = (`tempo` ≠ 0) && (`tempo` ≤ `LIMIAR_ALERTA`), from registers.

## Timing
- **Penalty latency:** `decresceT` high in cycle n → `tempo` reduced in cycle n+1.
- **Exhaustion latency:** if the reduction reaches 0, `tempo` = 0 and `fimT` = 1 appear together in cycle n+1.
- **Tick-driven expiry:** `tempo` = 0 and `fimT` = 1 appear in the cycle after the tick.
- **Reload latency:** `zeraT` in cycle n → `tempo` = `TEMPO_INICIAL` and `fimT` = 0 in cycle n+1.
- **Counting rate:** with `contaT` held high from a fresh reload, the first tick occurs `TICKS_POR_SEG` cycles after counting starts. Ticks then repeat every `TICKS_POR_SEG` cycles.
- **`fimT` stability:** once high, `fimT` stays high for as long as `zeraT` and `reset` stay deasserted. The control unit may sample it in any later cycle.
- **Reset mid-operation:** takes effect immediately and asynchronously. Deassertion is synchronised by the integrator, not by this block.

## Structure
- **Shared package** holds:
  - the state encodings `PARADO`/`CONTANDO`/`ESGOTADO`;
  - `LARGURA_TEMPO` = 8;
  - the default constants `TEMPO_INICIAL`, `PENALIDADE` and `LIMIAR_ALERTA`, so that the display and control logic agree on them.
- **Sub-module:** one, `prescaler_segundo`, a mod-`TICKS_POR_SEG` counter with enable and synchronous clear that outputs `tick`.
- **Top level:** the saturating subtract and the FSM live in `temporizador_partida` itself.

## Test plan
All directed scenarios use `TICKS_POR_SEG` = 4, `TEMPO_INICIAL` = 12, `PENALIDADE` = 5, `LIMIAR_ALERTA` = 3.
- **Reset:** reset low, then high → `tempo` = 12, `fimT` = 0, `alerta` = 0, `db_estado` = 00. Then `contaT` = 1 for 8 cycles → 2 tick pulses, `tempo` = 10, `db_estado` = 01.
- **Pause:** `contaT` = 1 for 2 cycles, 0 for 10 cycles, 1 for 2 cycles → exactly one tick, `tempo` = 11.
- **Penalty:** `decresceT` pulse at `tempo` = 12 → 7 next cycle. A pulse coincident with a tick at `tempo` = 7 → 1, with `alerta` = 1.
- **Saturation:** `decresceT` at `tempo` = 4 → `tempo` = 0 and `fimT` = 1 next cycle. Further `decresceT` pulses and `contaT` leave `tempo` = 0, `fimT` = 1 and `tick` = 0.
- **Reload priority:** while in `ESGOTADO`, assert `zeraT` together with `decresceT` → next cycle `tempo` = 12, `fimT` = 0, `db_estado` = 00.
- **Mid-count reset:** assert reset mid-count with `pre` = 2 → outputs return to reset values immediately. The next tick comes exactly 4 counting cycles after reset release.

Source files
------------

// File: rtl/temporizador_partida_pkg.sv
// -----------------------------------------------------------------------------
// temporizador_partida_pkg
// Shared definitions for the match countdown timer: FSM state encodings,
// width of the remaining-time value and the default timing constants, so the
// display path and the match control unit agree on them.
// -----------------------------------------------------------------------------
package temporizador_partida_pkg;

    // 2'b10 is deliberately left unused; the timer FSM recovers from it.
    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        CONTANDO = 2'b01,
        ESGOTADO = 2'b11
    } estado_t;

    localparam int LARGURA_TEMPO = 8;

    localparam int TEMPO_INICIAL = 60;  // seconds per match
    localparam int PENALIDADE    = 10;  // seconds lost per wrong move
    localparam int LIMIAR_ALERTA = 10;  // low-time warning threshold

endpackage : temporizador_partida_pkg

// File: rtl/temporizador_partida_prescaler_segundo.sv
// -----------------------------------------------------------------------------
// prescaler_segundo
// Mod-TICKS_POR_SEG counter that turns the system clock into a one-second
// strobe. Counting is gated by i_en so a pause resumes mid-second.
//
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   asynchronous, active-low reset
//   i_en    in   count enable
//   i_clr   in   synchronous clear (wins over i_en)
//   o_tick  out  high in the cycle where the count wraps to 0
// -----------------------------------------------------------------------------
module prescaler_segundo #(
    parameter int TICKS_POR_SEG = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int               PRE_W    = $clog2(TICKS_POR_SEG);
    localparam logic [PRE_W-1:0] C_ULTIMO = PRE_W'(TICKS_POR_SEG - 1);

    logic [PRE_W-1:0] r_pre;
    logic             w_wrap;

    assign w_wrap = i_en && (r_pre == C_ULTIMO);
    // A cleared cycle consumes no second, so it must not strobe.
    assign o_tick = w_wrap && !i_clr;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
        end else if (i_clr) begin
            r_pre <= '0;
        end else if (w_wrap) begin
            r_pre <= '0;
        end else if (i_en) begin
            r_pre <= r_pre + 1'b1;
        end
    end

endmodule : prescaler_segundo

// File: rtl/temporizador_partida.sv
// -----------------------------------------------------------------------------
// temporizador_partida
// Countdown timer for one training match. Keeps the remaining time in whole
// seconds, subtracts a fixed penalty per wrong move and raises fimT when the
// time is exhausted. fimT stays high until reloaded (zeraT) or reset.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   zeraT      in   synchronous reload to TEMPO_INICIAL (highest priority)
//   contaT     in   level; time runs while high
//   decresceT  in   single-cycle penalty strobe
//   fimT       out  high while time is exhausted
//   tempo      out  remaining seconds, unsigned
//   alerta     out  0 < tempo <= LIMIAR_ALERTA
//   tick       out  one-cycle pulse when a second is consumed
//   db_estado  out  FSM state for debug
// -----------------------------------------------------------------------------
module temporizador_partida
    import temporizador_partida_pkg::*;
#(
    parameter int TICKS_POR_SEG = 50_000_000,
    parameter int TEMPO_INICIAL = temporizador_partida_pkg::TEMPO_INICIAL,
    parameter int PENALIDADE    = temporizador_partida_pkg::PENALIDADE,
    parameter int LIMIAR_ALERTA = temporizador_partida_pkg::LIMIAR_ALERTA
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     zeraT,
    input  logic                     contaT,
    input  logic                     decresceT,
    output logic                     fimT,
    output logic [LARGURA_TEMPO-1:0] tempo,
    output logic                     alerta,
    output logic                     tick,
    output logic [1:0]               db_estado
);

    localparam logic [LARGURA_TEMPO-1:0] C_TEMPO_INI = LARGURA_TEMPO'(TEMPO_INICIAL);
    localparam logic [LARGURA_TEMPO-1:0] C_LIMIAR    = LARGURA_TEMPO'(LIMIAR_ALERTA);
    localparam logic signed [9:0]        C_PEN       = 10'(PENALIDADE);

    estado_t                  r_estado;
    estado_t                  w_estado_next;
    logic [LARGURA_TEMPO-1:0] r_tempo;
    logic [LARGURA_TEMPO-1:0] w_tempo_next;
    logic [LARGURA_TEMPO-1:0] w_tempo_sat;
    logic signed [9:0]        w_dif;
    logic                     w_conta_en;
    logic                     w_tick;

    // The prescaler freezes once time is exhausted.
    assign w_conta_en = contaT && (r_estado != ESGOTADO);

    prescaler_segundo #(
        .TICKS_POR_SEG(TICKS_POR_SEG)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .i_en  (w_conta_en),
        .i_clr (zeraT),
        .o_tick(w_tick)
    );

    // 10-bit signed difference covers 0 - 255 - 1 without wrapping, so a
    // negative result simply saturates to zero.
    assign w_dif       = $signed({2'b00, r_tempo})
                       - (decresceT ? C_PEN : 10'sd0)
                       - (w_tick ? 10'sd1 : 10'sd0);
    assign w_tempo_sat = w_dif[9] ? '0 : w_dif[LARGURA_TEMPO-1:0];

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_estado_next = r_estado;
        w_tempo_next  = r_tempo;
        if (zeraT) begin
            w_estado_next = PARADO;
            w_tempo_next  = C_TEMPO_INI;
        end else begin
            unique case (r_estado)
                ESGOTADO: begin
                    w_tempo_next = '0;
                end
                PARADO, CONTANDO: begin
                    w_tempo_next = w_tempo_sat;
                    // Also fires when tempo is already 0 from a parameter corner case.
                    if (w_tempo_sat == '0) begin
                        w_estado_next = ESGOTADO;
                    end else if (r_estado == PARADO && contaT) begin
                        w_estado_next = CONTANDO;
                    end else if (r_estado == CONTANDO && !contaT) begin
                        w_estado_next = PARADO;
                    end
                end
                default: begin
                    // Unused encoding 2'b10: recover to a safe idle state.
                    w_estado_next = PARADO;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= PARADO;
            r_tempo  <= C_TEMPO_INI;
        end else begin
            r_estado <= w_estado_next;
            r_tempo  <= w_tempo_next;
        end
    end

    assign fimT      = (r_estado == ESGOTADO);
    assign tempo     = r_tempo;
    assign alerta    = (r_tempo != '0) && (r_tempo <= C_LIMIAR);
    assign tick      = w_tick;
    assign db_estado = r_estado;

endmodule : temporizador_partida

// File: tb/tb_temporizador_partida.sv
// -----------------------------------------------------------------------------
// tb_temporizador_partida
// Self-checking bench for temporizador_partida with TICKS_POR_SEG = 4,
// TEMPO_INICIAL = 12, PENALIDADE = 5, LIMIAR_ALERTA = 3.
// Each vector holds one cycle of inputs, the tick expected during that cycle
// and the registered outputs expected after the following rising edge.
// -----------------------------------------------------------------------------
module tb_temporizador_partida;

    typedef struct {
        logic       zera;
        logic       conta;
        logic       dec;
        logic       exp_tick;
        logic [7:0] exp_tempo;
        logic       exp_fim;
        logic       exp_alerta;
        logic [1:0] exp_est;
        int         idx;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       zeraT;
    logic       contaT;
    logic       decresceT;
    logic       fimT;
    logic [7:0] tempo;
    logic       alerta;
    logic       tick;
    logic [1:0] db_estado;

    int   checks = 0;
    int   errors = 0;
    int   n_vec  = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clock = ~clock;

    temporizador_partida #(
        .TICKS_POR_SEG(4),
        .TEMPO_INICIAL(12),
        .PENALIDADE   (5),
        .LIMIAR_ALERTA(3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .zeraT    (zeraT),
        .contaT   (contaT),
        .decresceT(decresceT),
        .fimT     (fimT),
        .tempo    (tempo),
        .alerta   (alerta),
        .tick     (tick),
        .db_estado(db_estado)
    );

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h want %0h", name, idx, got, want);
        end
    endtask

    task automatic add(input logic z, input logic c, input logic d,
                       input logic tk, input logic [7:0] t,
                       input logic f, input logic a, input logic [1:0] e);
        vec_t v;
        v.zera = z; v.conta = c; v.dec = d;
        v.exp_tick = tk; v.exp_tempo = t; v.exp_fim = f;
        v.exp_alerta = a; v.exp_est = e; v.idx = n_vec;
        n_vec++;
        tbl.push_back(v);
    endtask

    // Drive each vector at the falling edge, check the combinational tick
    // mid-cycle and hand the registered expectations to the monitor.
    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            zeraT     = tbl[i].zera;
            contaT    = tbl[i].conta;
            decresceT = tbl[i].dec;
            #2;
            check("tick", tbl[i].idx, 32'(tick), 32'(tbl[i].exp_tick));
            exp_q.push_back(tbl[i]);
        end
        @(negedge clock);
        zeraT = 1'b0; contaT = 1'b0; decresceT = 1'b0;
        check("sb_drain", n_vec, exp_q.size(), 0);
        tbl.delete();
    endtask

    // Monitor: pops one expectation per rising edge and compares outputs.
    initial begin : monitor
        vec_t e;
        forever begin
            @(posedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                #1;
                check("tempo",     e.idx, 32'(tempo),     32'(e.exp_tempo));
                check("fimT",      e.idx, 32'(fimT),      32'(e.exp_fim));
                check("alerta",    e.idx, 32'(alerta),    32'(e.exp_alerta));
                check("db_estado", e.idx, 32'(db_estado), 32'(e.exp_est));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; zeraT = 1'b0; contaT = 1'b0; decresceT = 1'b0;
        #12;
        check("rst_tempo",  -1, 32'(tempo),     32'd12);
        check("rst_fimT",   -1, 32'(fimT),      32'd0);
        check("rst_alerta", -1, 32'(alerta),    32'd0);
        check("rst_estado", -1, 32'(db_estado), 32'd0);
        check("rst_tick",   -1, 32'(tick),      32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rel_tempo",  -1, 32'(tempo),     32'd12);
        check("rel_estado", -1, 32'(db_estado), 32'd0);

        // Count 8 cycles: ticks on the 4th and 8th, tempo 12 -> 10.
        for (int i = 1; i <= 8; i++)
            add(0, 1, 0, (i == 4 || i == 8), (i < 4) ? 8'd12 : (i < 8) ? 8'd11 : 8'd10, 0, 0, 2'b01);

        // Pause mid-second: 2 counting, 10 paused, 2 counting -> one tick.
        add(1, 0, 0, 0, 12, 0, 0, 2'b00);
        add(0, 1, 0, 0, 12, 0, 0, 2'b01);
        add(0, 1, 0, 0, 12, 0, 0, 2'b01);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 12, 0, 0, 2'b00);
        add(0, 1, 0, 0, 12, 0, 0, 2'b01);
        add(0, 1, 0, 1, 11, 0, 0, 2'b01);

        // Penalty 12 -> 7, then penalty coincident with a tick 7 -> 1.
        add(1, 0, 0, 0, 12, 0, 0, 2'b00);
        add(0, 0, 1, 0, 7, 0, 0, 2'b00);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 7, 0, 0, 2'b01);
        add(0, 1, 1, 1, 1, 0, 1, 2'b01);

        // Reach tempo = 4, then a penalty saturates to 0 and exhausts.
        add(1, 0, 0, 0, 12, 0, 0, 2'b00);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 12, 0, 0, 2'b01);
        add(0, 1, 1, 1, 6, 0, 0, 2'b01);
        for (int i = 1; i <= 8; i++)
            add(0, 1, 0, (i == 4 || i == 8), (i < 4) ? 8'd6 : (i < 8) ? 8'd5 : 8'd4, 0, 0, 2'b01);
        add(0, 0, 1, 0, 0, 1, 0, 2'b11);
        // Exhaustion hold: penalties and counting change nothing, no ticks.
        add(0, 1, 1, 0, 0, 1, 0, 2'b11);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 1, 0, 2'b11);
        add(0, 0, 1, 0, 0, 1, 0, 2'b11);

        // Reload wins over a simultaneous penalty.
        add(1, 0, 1, 0, 12, 0, 0, 2'b00);

        // Set up the mid-count reset: tempo 7, prescaler at 2.
        add(0, 0, 1, 0, 7, 0, 0, 2'b00);
        add(0, 1, 0, 0, 7, 0, 0, 2'b01);
        add(0, 1, 0, 0, 7, 0, 0, 2'b01);
        run_table();

        // Asynchronous reset mid-cycle with counting requested.
        contaT = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("arst_tempo",  -2, 32'(tempo),     32'd12);
        check("arst_fimT",   -2, 32'(fimT),      32'd0);
        check("arst_alerta", -2, 32'(alerta),    32'd0);
        check("arst_estado", -2, 32'(db_estado), 32'd0);
        check("arst_tick",   -2, 32'(tick),      32'd0);
        @(posedge clock);
        #1;
        check("arst_hold_tempo", -2, 32'(tempo), 32'd12);
        @(negedge clock);
        contaT = 1'b0;
        reset  = 1'b1;

        // After release the next tick arrives exactly on the 4th counting cycle.
        for (int i = 1; i <= 4; i++)
            add(0, 1, 0, (i == 4), (i < 4) ? 8'd12 : 8'd11, 0, 0, 2'b01);
        run_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_temporizador_partida
